grad_weight_sched: RTL and testbench
====================================

# grad_weight_sched

Sequential weight generator that sits directly after the gradient stage of the CFA interpolation pipeline. It accepts one horizontal/vertical gradient pair per transaction and applies the all-zero guard: when both gradients are zero, both are replaced by 1. It then time-shares a single restoring divider to produce the complementary fixed-point directional weights `w_h = floor(grad_v·2^FRAC / (grad_h+grad_v))` and `w_v = 2^FRAC − w_h`, which feed the green-channel blend. Both sides use valid/ready handshakes so the block can stall the gradient stage and be stalled by the blend stage.

## Interface
- `bitwidth`, 16: width of each gradient input.
- `FRAC`, 8: fractional bits of the weights; weights are FRAC+1 bits wide.
- `clk` input, 1: single clock; all state updates on its rising edge.
- `rst` input, 1: synchronous, active-high reset.
- `grad_h` input, bitwidth: horizontal gradient (unsigned).
- `grad_v` input, bitwidth: vertical gradient (unsigned).
- `in_valid` input, 1: gradient pair valid.
- `in_ready` output, 1: block can accept a pair.
- `w_h` output, FRAC+1: horizontal weight, range 0..2^FRAC.
- `w_v` output, FRAC+1: vertical weight, equal to 2^FRAC − w_h.
- `zero_flag` output, 1: both gradients were zero and were substituted.
- `out_valid` output, 1: weights valid.
- `out_ready` input, 1: downstream accepts the weights.
- `busy` output, 1: the state is not IDLE.

## Operation
- FSM states: IDLE, DIV, DONE.
- IDLE:
  - `in_ready=1`.
  - On `in_valid`:
    - Latch `gh`/`gv`, substituting 1/1 when both inputs are 0.
    - Latch `zero_flag`.
    - Set `sum = gh+gv` (bitwidth+1 bits, no overflow).
    - Set `rem = gv` (bitwidth+2 bits).
    - Set `cnt = FRAC`.
    - Clear the quotient.
    - Go to DIV.
- DIV: one quotient bit per cycle, MSB first, for bit index i = FRAC down to 0:
  - If `rem ≥ sum`, set `q[i]=1` and `rem = rem − sum`; otherwise `q[i]=0`.
  - Then shift `rem` left by 1.
  - At `cnt==0`, go to DONE. Otherwise decrement `cnt`.
- DONE:
  - `out_valid=1`.
  - `w_h=q` and `w_v=2^FRAC−q`; both are registered and held stable while `out_ready=0`.
  - On `out_valid & out_ready`, go to IDLE.
- `in_ready=0` in DIV and DONE. Input values presented there are ignored and must be held by the upstream stage.
- The quotient never exceeds 2^FRAC because gv ≤ sum, so no saturation logic is needed.
- `grad_h=0` with `grad_v≠0` gives `w_h=2^FRAC`, `w_v=0`. The symmetric case gives `w_h=0`, `w_v=2^FRAC`.
- `zero_flag` is valid only while `out_valid=1`.

## Timing
- Reset: state IDLE, `out_valid=0`, `w_h=0`, `w_v=0`, `zero_flag=0`, `busy=0`, `cnt=0`, `rem=0`. `in_ready=1` from the first cycle after reset.
- Reset mid-operation (DIV or DONE) abandons the transaction. No `out_valid` is produced for it.
- Acceptance edge is edge 0. DIV occupies edges 1..FRAC+1. `out_valid` rises after edge FRAC+1 (FRAC+2 cycles after the `in_valid` cycle).
- Minimum transaction period is FRAC+3 cycles: one cycle each for IDLE and DONE, plus FRAC+1 DIV cycles.
- No accept happens in the same cycle as an output handshake. IDLE is always re-entered for one cycle first.
- `in_ready`, `out_valid` and `busy` are decoded from the state register only; there is no combinational path from `in_valid` or `out_ready`.
- `in_valid` held high continuously is accepted at the first IDLE cycle only. The next pair is taken on the next IDLE cycle.

## Test plan
- **All-zero guard:** `grad_h=0`, `grad_v=0` → `zero_flag=1`, `w_h=128`, `w_v=128`, `out_valid` exactly 10 cycles after the accept cycle (FRAC=8).
- **One-sided and mid-range values:**
  - `grad_h=0`, `grad_v=50` → `w_h=256`, `w_v=0`, `zero_flag=0`.
  - `grad_h=50`, `grad_v=0` → `w_h=0`, `w_v=256`.
  - `grad_h=3`, `grad_v=1` → `w_h=64`, `w_v=192`.
  - `grad_h=2`, `grad_v=1` → `w_h=85`, `w_v=171` (truncation).
- **Full scale:** `grad_h=grad_v=65535` → `sum=131070` without overflow, `w_h=128`, `w_v=128`.
- **Backpressure:**
  - Hold `out_ready=0` for 20 cycles after `out_valid` → weights and `zero_flag` stay stable, `in_ready` stays 0.
  - Raise `out_ready` → next cycle is IDLE with `in_ready=1`.
- **Reset mid-operation:** assert `rst` for 1 cycle during DIV cycle 4 → `out_valid` never rises for that pair; the next pair (`grad_h=1`, `grad_v=3` → `w_h=192`) completes normally.
- **Streaming:** 1000 random pairs with `in_valid` always high and random `out_ready` → every `w_h` matches the floor-division model, `w_h+w_v=256`, output order is preserved, and no pair is dropped or duplicated.

Source files
------------

// File: rtl/grad_weight_sched_if.sv
// Handshake bundle between the gradient stage, grad_weight_sched and the
// green-channel blend stage.
//   grad_h/grad_v/in_valid/in_ready : gradient pair in (valid/ready)
//   w_h/w_v/zero_flag/out_valid/out_ready : weights out (valid/ready)
//   busy : weight generator is not idle
// slave is the weight generator's view; master is the surrounding pipeline.
interface grad_weight_sched_if #(
  parameter int unsigned bitwidth = 16,
  parameter int unsigned FRAC     = 8
);
  logic [bitwidth-1:0] grad_h;
  logic [bitwidth-1:0] grad_v;
  logic                in_valid;
  logic                in_ready;
  logic [FRAC:0]       w_h;
  logic [FRAC:0]       w_v;
  logic                zero_flag;
  logic                out_valid;
  logic                out_ready;
  logic                busy;

  modport slave (
    input  grad_h, grad_v, in_valid, out_ready,
    output in_ready, w_h, w_v, zero_flag, out_valid, busy
  );

  modport master (
    output grad_h, grad_v, in_valid, out_ready,
    input  in_ready, w_h, w_v, zero_flag, out_valid, busy
  );
endinterface

// File: rtl/grad_weight_sched.sv
// Directional weight generator for the CFA green interpolation.
// Takes one gradient pair, applies the all-zero guard (0/0 -> 1/1) and runs a
// restoring divider one quotient bit per cycle to form
//   w_h = floor(gv * 2^FRAC / (gh + gv)),  w_v = 2^FRAC - w_h.
// Ports:
//   clk  : clock, rising edge
//   rst  : synchronous active-high reset
//   bus  : grad_weight_sched_if.slave (input pair handshake, weight handshake,
//          busy status)
module grad_weight_sched #(
  parameter int unsigned bitwidth = 16,
  parameter int unsigned FRAC     = 8
) (
  input logic                clk,
  input logic                rst,
  grad_weight_sched_if.slave bus
);

  localparam int unsigned WW = FRAC + 1;       // weight width
  localparam int unsigned SW = bitwidth + 1;   // divisor width, gh+gv never overflows
  localparam int unsigned RW = bitwidth + 2;   // partial remainder width
  localparam int unsigned CW = $clog2(FRAC + 1);

  localparam logic [WW-1:0] W_FULL = {1'b1, {FRAC{1'b0}}};

  typedef enum logic [1:0] {
    IDLE,
    DIV,
    DONE
  } state_t;

  state_t          state;
  logic [SW-1:0]   sum;
  logic [RW-1:0]   rem;
  logic [CW-1:0]   cnt;
  logic [WW-1:0]   q;
  logic [WW-1:0]   w_h_q;
  logic [WW-1:0]   w_v_q;
  logic            zero_q;

  // All-zero guard on the incoming pair
  logic                in_zero;
  logic [bitwidth-1:0] gh_g;
  logic [bitwidth-1:0] gv_g;

  assign in_zero = (bus.grad_h == '0) && (bus.grad_v == '0);
  assign gh_g    = in_zero ? bitwidth'(1) : bus.grad_h;
  assign gv_g    = in_zero ? bitwidth'(1) : bus.grad_v;

  // One restoring-division step for quotient bit index cnt
  logic            rem_ge;
  logic [RW-1:0]   rem_sub;
  logic [WW-1:0]   q_next;

  assign rem_ge  = rem >= RW'(sum);
  assign rem_sub = rem_ge ? (rem - RW'(sum)) : rem;
  assign q_next  = rem_ge ? (q | (WW'(1) << cnt)) : q;

  // Controller and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      sum    <= '0;
      rem    <= '0;
      cnt    <= '0;
      q      <= '0;
      w_h_q  <= '0;
      w_v_q  <= '0;
      zero_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            zero_q <= in_zero;
            sum    <= SW'(gh_g) + SW'(gv_g);
            rem    <= RW'(gv_g);
            cnt    <= CW'(FRAC);
            q      <= '0;
            state  <= DIV;
          end
        end
        DIV: begin
          q   <= q_next;
          // rem_sub < sum, so the shifted value still fits in RW bits
          rem <= {rem_sub[RW-2:0], 1'b0};
          if (cnt == '0) begin
            w_h_q <= q_next;
            w_v_q <= W_FULL - q_next;
            state <= DONE;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Handshake/status outputs decode the state register only
  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == DONE);
  assign bus.busy      = (state != IDLE);
  assign bus.w_h       = w_h_q;
  assign bus.w_v       = w_v_q;
  assign bus.zero_flag = zero_q;

endmodule

// File: tb/tb_grad_weight_sched.sv
// Scoreboard bench for grad_weight_sched: the driver pushes the expected
// weights when a pair is accepted, a monitor pops and compares on every
// output handshake.
module tb_grad_weight_sched;

  localparam int unsigned BW   = 16;
  localparam int unsigned FRAC = 8;

  typedef struct {
    logic [8:0] wh;
    logic       zf;
  } exp_t;

  typedef struct {
    logic [15:0] h;
    logic [15:0] v;
    logic [8:0]  wh;
    logic        zf;
  } vec_t;

  logic clk;
  logic rst;

  grad_weight_sched_if #(.bitwidth(BW), .FRAC(FRAC)) bus ();

  grad_weight_sched #(.bitwidth(BW), .FRAC(FRAC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  exp_t sb[$];
  int   n_cmp  = 0;
  int   n_fail = 0;
  int   n_push = 0;
  int   n_pop  = 0;
  bit   rand_rdy = 1'b0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Independent floor-division reference
  function automatic logic [8:0] model_wh(input logic [15:0] h, input logic [15:0] v);
    longint unsigned hh, vv;
    hh = h;
    vv = v;
    if (hh == 0 && vv == 0) begin
      hh = 1;
      vv = 1;
    end
    return 9'((vv * 256) / (hh + vv));
  endfunction

  // Present a pair; returns at the acceptance edge + 1 time unit
  task automatic send(input logic [15:0] h, input logic [15:0] v, input logic [8:0] ewh,
                      input logic ezf, input bit push, input bit keep);
    bit ok;
    ok = 1'b0;
    bus.grad_h   = h;
    bus.grad_v   = v;
    bus.in_valid = 1'b1;
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      n_cmp++;
      n_fail++;
      $display("FAIL accept_timeout: got no in_ready, required in_ready=1");
    end else if (push) begin
      sb.push_back('{wh: ewh, zf: ezf});
      n_push++;
    end
    @(posedge clk);
    #1;
    if (!keep) bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < 3000; k++) begin
      @(negedge clk);
      if (sb.size() == 0 && !bus.busy) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      n_cmp++;
      n_fail++;
      $display("FAIL drain_timeout: got %0d pending, required 0", sb.size());
    end
  endtask

  // Monitor: compare every output handshake against the scoreboard head
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (bus.out_valid && bus.out_ready) begin
        n_pop++;
        if (sb.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL unexpected_out: got w_h=%0d with no pending pair, required none", bus.w_h);
        end else begin
          e = sb.pop_front();
          check("w_h", 64'(bus.w_h), 64'(e.wh));
          check("w_v", 64'(bus.w_v), 64'(9'd256 - e.wh));
          check("zero_flag", 64'(bus.zero_flag), 64'(e.zf));
        end
      end
    end
  end

  // Random downstream backpressure during streaming
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rand_rdy) bus.out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  // Watchdog
  initial begin
    #5ms;
    $display("FAIL watchdog: got no finish, required finish before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t dir[6];
    int   k;
    logic [15:0] h, v;
    int   mode;

    dir[0] = '{h: 16'd0,     v: 16'd50,    wh: 9'd256, zf: 1'b0};
    dir[1] = '{h: 16'd50,    v: 16'd0,     wh: 9'd0,   zf: 1'b0};
    dir[2] = '{h: 16'd3,     v: 16'd1,     wh: 9'd64,  zf: 1'b0};
    dir[3] = '{h: 16'd2,     v: 16'd1,     wh: 9'd85,  zf: 1'b0};
    dir[4] = '{h: 16'd65535, v: 16'd65535, wh: 9'd128, zf: 1'b0};
    dir[5] = '{h: 16'd0,     v: 16'd0,     wh: 9'd128, zf: 1'b1};

    rst           = 1'b1;
    bus.grad_h    = '0;
    bus.grad_v    = '0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset state
    @(negedge clk);
    check("rst_in_ready", 64'(bus.in_ready), 64'd1);
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_w_h", 64'(bus.w_h), 64'd0);
    check("rst_w_v", 64'(bus.w_v), 64'd0);
    check("rst_zero_flag", 64'(bus.zero_flag), 64'd0);
    @(posedge clk);
    #1;

    // All-zero guard, latency and backpressure hold
    send(16'd0, 16'd0, 9'd128, 1'b1, 1'b1, 1'b0);
    k = 0;
    do begin
      @(negedge clk);
      k++;
      if (k == 1) begin
        check("div_in_ready", 64'(bus.in_ready), 64'd0);
        check("div_busy", 64'(bus.busy), 64'd1);
      end
    end while (!bus.out_valid && k < 40);
    check("latency", 64'(k), 64'd10);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("hold_out_valid", 64'(bus.out_valid), 64'd1);
      check("hold_w_h", 64'(bus.w_h), 64'd128);
      check("hold_w_v", 64'(bus.w_v), 64'd128);
      check("hold_zero_flag", 64'(bus.zero_flag), 64'd1);
      check("hold_in_ready", 64'(bus.in_ready), 64'd0);
    end
    @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("release_in_ready", 64'(bus.in_ready), 64'd1);
    check("release_out_valid", 64'(bus.out_valid), 64'd0);
    @(posedge clk);
    #1;

    // Directed vectors
    foreach (dir[i]) send(dir[i].h, dir[i].v, dir[i].wh, dir[i].zf, 1'b1, 1'b0);
    drain();

    // Reset during the fourth DIV cycle abandons the pair
    @(posedge clk);
    #1;
    send(16'd5, 16'd7, 9'd0, 1'b0, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("midrst_in_ready", 64'(bus.in_ready), 64'd1);
    check("midrst_busy", 64'(bus.busy), 64'd0);
    k = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (bus.out_valid) k++;
    end
    check("midrst_no_out_valid", 64'(k), 64'd0);
    @(posedge clk);
    #1;
    send(16'd1, 16'd3, 9'd192, 1'b0, 1'b1, 1'b0);
    drain();

    // Streaming with in_valid held high and random out_ready
    @(posedge clk);
    #1;
    rand_rdy = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      mode = $urandom_range(0, 7);
      h = 16'($urandom_range(0, 1000));
      v = 16'($urandom_range(0, 1000));
      case (mode)
        0: begin h = '0; v = '0; end
        1: h = '0;
        2: v = '0;
        3: begin h = 16'($urandom); v = 16'($urandom); end
        default: ;
      endcase
      send(h, v, model_wh(h, v), (h == 0 && v == 0), 1'b1, 1'b1);
    end
    bus.in_valid = 1'b0;
    rand_rdy = 1'b0;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
    drain();

    check("pairs_out_vs_in", 64'(n_pop), 64'(n_push));
    check("scoreboard_empty", 64'(sb.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
